regfile_wb_arbiter: RTL and testbench

//   Shares the single register-file write port between NUM_REQ writeback sources (ALU, load unit, mul/div).

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 65 ++++++
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_pkg
// Purpose  : Shared writeback-source indices and sizing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int NUM_WB_REQ    = 3;
    localparam int WB_SRC_ALU    = 0;
    localparam int WB_SRC_LOAD   = 1;
    localparam int WB_SRC_MULDIV = 2;

    typedef enum logic [1:0] {
        SRC_ALU    = 2'd0,
        SRC_LOAD   = 2'd1,
        SRC_MULDIV = 2'd2
    } wb_src_e;

    // A one-requester pointer would otherwise collapse to zero bits.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter; owns the priority pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_any
);

    localparam logic [PTR_W:0]   C_NUM  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (w_sum >= C_NUM) begin
                w_sum = w_sum - C_NUM;
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!grant_any && valid[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
                grant_any    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == C_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the regfile write port among writeback sources and keeps
//            the per-register busy scoreboard used by decode.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_WB_REQ,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    input  logic                      reserve_valid,
    input  logic [ADDR_W-1:0]         reserve_rd,
    output logic                      reserve_ready,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         rs1_address,
    input  logic [ADDR_W-1:0]         rs2_address,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         rd_address,
    output logic [XLEN-1:0]           rd_data
);

    localparam int C_NUM_REGS = 1 << ADDR_W;
    localparam int C_PTR_W    = ptr_width(NUM_REQ);

    logic [NUM_REQ-1:0]    w_grant;
    logic [C_PTR_W-1:0]    w_grant_idx;
    logic                  w_grant_any;
    logic                  w_handshake;
    logic                  w_reserve_set;
    logic [ADDR_W-1:0]     w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;

    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]       rd_data_q, rd_data_d;
    logic [C_NUM_REGS-1:0] busy_q,    busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (C_PTR_W)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset_n   (reset_n),
        .valid     (req_valid),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    // Grants are visible combinationally but suppressed while reset is held.
    assign req_ready   = reset_n ? w_grant : '0;
    assign w_handshake = reset_n & w_grant_any;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == C_PTR_W'(i)) begin
                w_sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes still consume a grant but never reach the regfile.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (w_handshake) begin
            wr_en_d   = (w_sel_rd != '0);
            rd_addr_d = w_sel_rd;
            rd_data_d = w_sel_data;
        end
    end

    assign reserve_ready = reset_n & (~busy_q[reserve_rd] | (reserve_rd == '0));
    assign w_reserve_set = reserve_valid & reserve_ready & (reserve_rd != '0);

    // Priority: retire clear, then reservation set, then flush over everything.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[rd_addr_q] = 1'b0;
        end
        if (w_reserve_set) begin
            busy_d[reserve_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign rs1_busy     = busy_q[rs1_address];
    assign rs2_busy     = busy_q[rs2_address];
    assign write_enable = wr_en_q;
    assign rd_address   = rd_addr_q;
    assign rd_data      = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Scoreboard bench for regfile_wb_arbiter with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int NR = NUM_WB_REQ;
    localparam int XL = 32;
    localparam int AW = 5;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*AW-1:0]   req_rd = '0;
    logic [NR*XL-1:0]   req_data = '0;
    logic               reserve_valid = 1'b0;
    logic [AW-1:0]      reserve_rd = '0;
    logic               reserve_ready;
    logic               flush = 1'b0;
    logic [AW-1:0]      rs1_address = '0;
    logic [AW-1:0]      rs2_address = '0;
    logic               rs1_busy;
    logic               rs2_busy;
    logic               write_enable;
    logic [AW-1:0]      rd_address;
    logic [XL-1:0]      rd_data;

    regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XL), .ADDR_W(AW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .reserve_valid (reserve_valid),
        .reserve_rd    (reserve_rd),
        .reserve_ready (reserve_ready),
        .flush         (flush),
        .rs1_address   (rs1_address),
        .rs2_address   (rs2_address),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .write_enable  (write_enable),
        .rd_address    (rd_address),
        .rd_data       (rd_data)
    );

    always #5 clock = ~clock;

    logic [XL-1:0] rf [32];
    always @(posedge clock) begin
        if (write_enable) rf[rd_address] <= rd_data;
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] rd;
        logic [XL-1:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur = '0;
    logic [31:0] m_busy = '0;
    int          m_ptr = 0;
    int          g_last = -1;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XL-1:0] d);
        req_rd[i*AW +: AW]   = rd;
        req_data[i*XL +: XL] = d;
    endtask

    // One clock: check combinational outputs at the falling edge against the
    // model, push the predicted output-register contents, pop after the edge.
    task automatic cycle();
        int            g;
        int            idx;
        logic [NR-1:0] exp_ready;
        logic          rr;
        logic [31:0]   nb;
        wr_t           e;
        wr_t           o;
        @(negedge clock);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        rr = !m_busy[reserve_rd] || (reserve_rd == 0);
        chk("reserve_ready", 64'(reserve_ready), 64'(rr));
        chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1_address]));
        chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2_address]));
        nb = m_busy;
        if (cur.we) nb[cur.rd] = 1'b0;
        if (reserve_valid && rr && reserve_rd != 0) nb[reserve_rd] = 1'b1;
        if (flush) nb = '0;
        e = cur;
        e.we = 1'b0;
        if (g >= 0) begin
            e.rd   = req_rd[g*AW +: AW];
            e.data = req_data[g*XL +: XL];
            e.we   = (e.rd != 0);
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        o = exp_q.pop_front();
        chk("write_enable", 64'(write_enable), 64'(o.we));
        if (o.we) begin
            chk("rd_address", 64'(rd_address), 64'(o.rd));
            chk("rd_data", 64'(rd_data), 64'(o.data));
        end
        cur    = o;
        m_busy = nb;
        if (g >= 0) m_ptr = (g + 1) % NR;
        g_last = g;
    endtask

    initial begin
        // Reset state
        req_valid     = '1;
        reserve_valid = 1'b1;
        reserve_rd    = 5'd3;
        #12;
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_addr", 64'(rd_address), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsv_ready", 64'(reserve_ready), 64'd0);
        req_valid     = '0;
        reserve_valid = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Round robin with all sources held valid
        for (int i = 0; i < NR; i++) set_req(i, AW'(10 + i), 32'hA000_0000 + 32'(i));
        req_valid = '1;
        for (int n = 0; n < 6; n++) begin
            cycle();
            set_req(g_last, AW'(10 + g_last), 32'hB000_0000 + 32'(n * 16 + g_last));
        end
        req_valid = '0;
        cycle();

        // Reserve x5, retire it through the load unit
        rs1_address   = 5'd5;
        rs2_address   = 5'd7;
        reserve_valid = 1'b1;
        reserve_rd    = 5'd5;
        cycle();
        reserve_valid = 1'b0;
        cycle();
        set_req(WB_SRC_LOAD, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        cycle();
        req_valid = '0;
        chk("x5_busy_before_commit", 64'(rs1_busy), 64'd1);
        cycle();
        cycle();
        chk("rf_x5", 64'(rf[5]), 64'hDEAD_BEEF);

        // WAW stall on x7; set-and-clear race on unreserved x8
        reserve_valid = 1'b1;
        reserve_rd    = 5'd7;
        cycle();
        cycle();
        reserve_valid = 1'b0;
        set_req(WB_SRC_ALU, 5'd7, 32'h0000_0777);
        req_valid = 3'b001;
        cycle();
        req_valid     = '0;
        reserve_valid = 1'b1;
        cycle();
        reserve_valid = 1'b0;
        rs2_address   = 5'd8;
        set_req(WB_SRC_MULDIV, 5'd8, 32'h0000_0888);
        req_valid = 3'b100;
        cycle();
        req_valid     = '0;
        reserve_valid = 1'b1;
        reserve_rd    = 5'd8;
        cycle();
        reserve_valid = 1'b0;
        cycle();
        chk("x8_set_wins", 64'(rs2_busy), 64'd1);

        // Write to x0 is granted but dropped, pointer still advances
        set_req(WB_SRC_ALU, 5'd0, 32'h0000_1234);
        req_valid = 3'b001;
        cycle();
        req_valid = '0;
        cycle();
        set_req(WB_SRC_ALU, 5'd11, 32'h0000_0011);
        set_req(WB_SRC_LOAD, 5'd12, 32'h0000_0012);
        set_req(WB_SRC_MULDIV, 5'd13, 32'h0000_0013);
        req_valid = '1;
        #1;
        chk("ptr_after_x0", 64'(req_ready), 64'b010);
        cycle();
        req_valid = '0;
        cycle();

        // Flush beside a pending write and a same-cycle reservation
        reserve_valid = 1'b1;
        reserve_rd    = 5'd3;
        cycle();
        reserve_rd    = 5'd9;
        cycle();
        reserve_valid = 1'b0;
        set_req(WB_SRC_ALU, 5'd3, 32'h3333_3333);
        req_valid = 3'b001;
        cycle();
        req_valid     = '0;
        flush         = 1'b1;
        reserve_valid = 1'b1;
        reserve_rd    = 5'd4;
        cycle();
        flush         = 1'b0;
        reserve_valid = 1'b0;
        rs1_address   = 5'd4;
        rs2_address   = 5'd9;
        cycle();
        chk("rf_x3_after_flush", 64'(rf[3]), 64'h3333_3333);
        chk("x4_flushed", 64'(rs1_busy), 64'd0);

        // Reset mid-operation
        reserve_valid = 1'b1;
        for (int r = 1; r < 32; r++) begin
            reserve_rd = AW'(r);
            cycle();
        end
        reserve_valid = 1'b0;
        rs1_address   = 5'd12;
        rs2_address   = 5'd31;
        set_req(WB_SRC_LOAD, 5'd12, 32'hCAFE_0012);
        req_valid = 3'b010;
        cycle();
        chk("pre_rst_we", 64'(write_enable), 64'd1);
        chk("pre_rst_busy", 64'(rs1_busy), 64'd1);
        req_valid     = '1;
        reserve_valid = 1'b1;
        reserve_rd    = 5'd20;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(write_enable), 64'd0);
        chk("mid_rst_addr", 64'(rd_address), 64'd0);
        chk("mid_rst_data", 64'(rd_data), 64'd0);
        chk("mid_rst_rs1", 64'(rs1_busy), 64'd0);
        chk("mid_rst_rs2", 64'(rs2_busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rsv", 64'(reserve_ready), 64'd0);
        req_valid     = '0;
        reserve_valid = 1'b0;
        m_busy = '0;
        m_ptr  = 0;
        cur    = '0;
        exp_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        req_valid = '1;
        #1;
        chk("first_grant_after_rst", 64'(req_ready), 64'b001);
        cycle();
        req_valid = '0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
